// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial adder time-sharing one 4-bit carry-lookahead slice
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int N = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_c;
    logic [KW-1:0]    r_k;
    logic [3:0]       w_na, w_nb, w_g, w_p, w_s;
    logic [4:0]       w_c;

    assign w_na = r_a[4*r_k +: 4];
    assign w_nb = r_b[4*r_k +: 4];
    assign w_g  = w_na & w_nb;
    assign w_p  = w_na ^ w_nb;
    assign w_c[0] = r_c;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_s  = w_p ^ w_c[3:0];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_c;
    assign ovf       = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: accept in IDLE, leave RUN after the top nibble, drain DONE on out_ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? RUN : IDLE;
            RUN:     w_next = (r_k == K_LAST) ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latch on accept, then one nibble per cycle LSB first through the slice
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_k   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_a <= a;
            r_b <= b;
            r_c <= cin;
            r_k <= '0;
        end else if (r_state == RUN) begin
            r_sum[4*r_k +: 4] <= w_s;
            r_c               <= w_c[4];
            r_k               <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed corner cases plus randomized back-to-back traffic against an arithmetic model
module tb_cla_seq_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition; result packed as {cout, ovf, sum}
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] u;
        int         s;
        u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return {u[W], (s > 32767 || s < -32768), u[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        for (int i = 0; i < 50 && !in_ready; i++) tick;
        check("start_ready", 32'(in_ready), 32'd1);
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] s, input logic co, input logic ov);
        check({tag, "_sum"}, 32'(sum), 32'(s));
        check({tag, "_cout"}, 32'(cout), 32'(co));
        check({tag, "_ovf"}, 32'(ovf), 32'(ov));
    endtask

    logic [W+1:0] q[$];
    logic [W+1:0] exp_r;
    logic [W-1:0] held;
    int           lat;
    int           got;
    int           cyc;
    logic         seen;

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        expect_result("rst", 16'h0000, 1'b0, 1'b0);

        start(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("lat_ffff", 32'(lat), 32'(N + 1));
        expect_result("ffff_1", 16'h0000, 1'b1, 1'b0);
        tick;

        start(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("lat_7fff", 32'(lat), 32'(N + 1));
        expect_result("7fff_1", 16'h8000, 1'b0, 1'b1);
        tick;

        start(16'h8000, 16'h8000, 1'b1);
        wait_done(lat);
        expect_result("8000_8000", 16'h0001, 1'b1, 1'b1);
        tick;
        check("throughput_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b0;
        start(16'h1357, 16'h2468, 1'b1);
        wait_done(lat);
        held = sum;
        expect_result("hold_first", 16'h37C0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);

        start(16'h1111, 16'h2222, 1'b0);
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b1;
        in_valid = 1'b1;
        wait_done(lat);
        check("ignore_lat", 32'(lat), 32'(N + 1));
        expect_result("ignore", 16'h3333, 1'b0, 1'b0);
        tick;
        check("ignore_idle", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("second_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("second_lat", 32'(lat), 32'(N + 1));
        expect_result("second", 16'h0000, 1'b1, 1'b0);
        tick;

        start(16'hF0F0, 16'h0F0F, 1'b1);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        expect_result("midrst", 16'h0000, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | out_valid;
            tick;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        start(16'h1234, 16'h4321, 1'b0);
        wait_done(lat);
        expect_result("after_rst", 16'h5555, 1'b0, 1'b0);
        tick;

        got = 0;
        cyc = 0;
        while (got < 10000 && cyc < 75000) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            out_ready = ($urandom_range(7) != 0);
            @(negedge clk);
            if (in_valid && in_ready) q.push_back(ref_model(a, b, cin));
            if (out_valid && out_ready) begin
                got++;
                if (q.size() == 0) begin
                    check("rand_underflow", 32'(q.size()), 32'd1);
                end else begin
                    exp_r = q.pop_front();
                    check("rand", 32'({cout, ovf, sum}), 32'(exp_r));
                end
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_count", 32'(got), 32'd10000);
        check("rand_leftover", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
